meas_frame_scheduler: RTL and testbench
=======================================

Name: meas_frame_scheduler

Overview:
- Shares one byte-serial uplink (UART transmitter) between NUM_CH measurement channels.
- Each channel is a grating-measurement engine. It delivers a 32-bit result word per group: RESR delta in [31:16], RGS count in [15:0].
- Each word is latched into a per-channel holding slot. The block arbitrates round-robin, then serialises one framed, checksummed packet per grant, pacing bytes on the transmitter busy handshake.

Parameters:
- NUM_CH, 2, number of measurement channels (1..8)
- SYNC_BYTE, 8'hA5, first byte of every packet
- CH_W, 3, width of channel index field

Ports:
- CLOCK_50M  in  1  system clock, 50 MHz
- RST_n  in  1  reset, synchronous, active-low
- iFrame_Valid  in  NUM_CH  one-cycle strobe per channel: result word present
- iFrame_Data  in  32*NUM_CH  channel k word at [32k+31:32k]
- iEnable  in  1  permits starting new packets
- iTx_Busy  in  1  transmitter busy; high from the cycle after oTx_Start until the byte is done
- oTx_Start  out  1  one-cycle strobe: oTx_Data valid, start transmission
- oTx_Data  out  8  byte to transmit
- oBusy  out  1  packet in progress
- oActive_Ch  out  CH_W  channel index of current or last packet
- oOverrun_Count  out  16  frames overwritten before being sent, saturating

Behaviour:
- Reset (RST_n low at a clock edge):
  - All slots empty; FSM to IDLE.
  - oTx_Start=0, oTx_Data=0, oBusy=0, oActive_Ch=0, oOverrun_Count=0.
  - Round-robin pointer = 0.
  - Reset mid-packet aborts immediately; no further oTx_Start.
- Slot capture:
  - iFrame_Valid[k]=1 writes iFrame_Data[k] into slot k and sets pending[k].
  - If pending[k] was already 1 and slot k is not being loaded this cycle: overwrite, oOverrun_Count +1, saturating at 16'hFFFF.
  - Multiple channels may capture in the same cycle; each counts its own overrun, so the count can rise by more than 1.
- Load/capture collision on slot k: LOAD clears pending[k] and copies the old word; the new word is stored with pending[k]=1. No overrun is counted.
- Arbitration, in IDLE with iEnable=1 and any pending:
  - Grant the first pending channel at or after pointer, wrapping modulo NUM_CH.
  - Pointer becomes grant+1, wrapping (NUM_CH-1 -> 0).
- FSM:
  - IDLE: on grant -> LOAD.
  - LOAD (1 cycle): build the 7-byte packet into the shift buffer, clear pending[grant], set oActive_Ch=grant, oBusy=1, byte index=0 -> ISSUE.
  - ISSUE: when iTx_Busy=0, drive oTx_Data=byte[index] and oTx_Start=1 for one cycle -> HOLD.
  - HOLD (1 cycle, ignores iTx_Busy) -> DRAIN.
  - DRAIN: on iTx_Busy=0: if index=6 -> IDLE with oBusy=0; else index+1 -> ISSUE.
- Packet format:
  - byte0=SYNC_BYTE
  - byte1={5'b0,ch}
  - byte2..5 = data[31:24], [23:16], [15:8], [7:0]
  - byte6 = 8-bit modulo-256 sum of byte1..byte5
- Timing:
  - Minimum latency from iFrame_Valid to first oTx_Start is 3 cycles: capture, IDLE grant, LOAD, ISSUE.
  - Back-to-back packets take 1 IDLE cycle between the last DRAIN and the next LOAD.
- iEnable:
  - Deasserting iEnable never truncates a packet.
  - It only blocks IDLE->LOAD; capture and overrun counting continue.
- oTx_Data holds its last value when oTx_Start=0.

Decomposition:
- Shared package meas_pkg:
  - localparam FRAME_BYTES=7
  - default SYNC_BYTE
  - FSM state enum {IDLE, LOAD, ISSUE, HOLD, DRAIN}
  - field offsets RESR_MSB=31, RGS_MSB=15
- One sub-module, meas_rr_arbiter: combinational pending/pointer -> grant and grant_valid, plus the registered pointer update.

Test Plan:
- Single frame, ch0, data 32'h0012_0345, iTx_Busy modelled for 10 cycles per byte -> bytes A5,00,00,12,03,45,5A. One oTx_Start per byte, never while busy; oBusy falls after byte6 completes.
- Simultaneous iFrame_Valid=2'b11, ch0=32'h1, ch1=32'h2, pointer 0 -> ch0 packet (byte6=01), then ch1 packet (byte1=01, byte6=03). A second simultaneous pair after that yields ch0 before ch1 again.
- ch1 strobed 3 times while ch0's packet is sending (pending ch1) -> oOverrun_Count=2; only the last ch1 word is transmitted.
- ch0 strobed in the exact LOAD cycle of ch0 with a new word 32'hAAAA_BBBB -> old word sent, then a second packet with AA,AA,BB,BB. oOverrun_Count unchanged.
- iEnable dropped after byte2 issues -> packet completes all 7 bytes. A frame arriving meanwhile is not sent until iEnable=1, then sent within 3 cycles.
- RST_n low for 1 cycle during byte4 -> no further oTx_Start, all outputs at reset values, slots empty. A frame after reset is sent from byte0.

Source files
------------

// File: rtl/meas_pkg.sv
// Shared definitions for the measurement frame scheduler: packet geometry,
// result-word field positions, FSM state encoding and the packet checksum.
package meas_pkg;

    localparam int FRAME_BYTES = 7;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam int RESR_MSB = 31;
    localparam int RGS_MSB = 15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_e;

    function automatic logic [7:0] frame_checksum(input logic [7:0] ch_byte,
                                                  input logic [31:0] word);
        return ch_byte + word[31:24] + word[23:16] + word[15:8] + word[7:0];
    endfunction

endpackage

// File: rtl/meas_rr_arbiter.sv
// Round-robin arbiter: picks the first pending channel at or after the
// pointer (wrapping) and moves the pointer past each accepted grant.
module meas_rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] i_pending,
    input  logic              i_advance,
    output logic [CH_W-1:0]   o_grant,
    output logic              o_grant_valid
);

    logic [CH_W-1:0] r_ptr;
    logic [CH_W:0]   w_dist;
    logic [CH_W:0]   w_best;
    logic            w_take_j;

    // Smallest wrap-around distance from the pointer wins the grant.
    always_comb begin
        o_grant       = {CH_W{1'b0}};
        o_grant_valid = 1'b0;
        w_best        = (CH_W+1)'(NUM_CH);
        w_dist        = {(CH_W+1){1'b0}};
        w_take_j      = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            w_dist = (CH_W'(j) >= r_ptr) ? ((CH_W+1)'(j) - {1'b0, r_ptr})
                                         : ((CH_W+1)'(j + NUM_CH) - {1'b0, r_ptr});
            w_take_j      = i_pending[j] && (w_dist < w_best);
            w_best        = w_take_j ? w_dist : w_best;
            o_grant       = w_take_j ? CH_W'(j) : o_grant;
            o_grant_valid = o_grant_valid | w_take_j;
        end
    end

    // Pointer update on an accepted grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= {CH_W{1'b0}};
        end else if (i_advance) begin
            r_ptr <= (o_grant == CH_W'(NUM_CH-1)) ? {CH_W{1'b0}} : (o_grant + CH_W'(1));
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/meas_frame_scheduler.sv
// Multiplexes per-channel 32-bit measurement results onto one byte-serial
// uplink as framed, checksummed 7-byte packets with round-robin fairness.
module meas_frame_scheduler
    import meas_pkg::*;
#(
    parameter int         NUM_CH    = 2,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
    parameter int         CH_W      = 3
) (
    input  logic                CLOCK_50M,
    input  logic                RST_n,
    input  logic [NUM_CH-1:0]   iFrame_Valid,
    input  logic [32*NUM_CH-1:0] iFrame_Data,
    input  logic                iEnable,
    input  logic                iTx_Busy,
    output logic                oTx_Start,
    output logic [7:0]          oTx_Data,
    output logic                oBusy,
    output logic [CH_W-1:0]     oActive_Ch,
    output logic [15:0]         oOverrun_Count
);

    localparam int PKT_W = 8 * FRAME_BYTES;

    state_e            r_state;
    logic [31:0]       r_slot [NUM_CH];
    logic [NUM_CH-1:0] r_pending;
    logic [CH_W-1:0]   r_grant;
    logic [PKT_W-1:0]  r_pkt;
    logic [2:0]        r_idx;
    logic              r_tx_start;
    logic [7:0]        r_tx_data;
    logic              r_busy;
    logic [CH_W-1:0]   r_active_ch;
    logic [15:0]       r_ovr_cnt;

    logic [CH_W-1:0]   w_grant;
    logic              w_grant_valid;
    logic              w_take;
    logic              w_load;
    logic [NUM_CH-1:0] w_hit;
    logic [NUM_CH-1:0] w_pend_nxt;
    logic [31:0]       w_load_word;
    logic [3:0]        w_ovr_inc;
    logic [16:0]       w_ovr_sum;
    logic [7:0]        w_ch_byte;

    assign w_take    = (r_state == IDLE) && iEnable && w_grant_valid;
    assign w_load    = (r_state == LOAD);
    assign w_ch_byte = 8'(r_grant);
    assign w_ovr_sum = {1'b0, r_ovr_cnt} + 17'(w_ovr_inc);

    meas_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .clk           (CLOCK_50M),
        .rst_n         (RST_n),
        .i_pending     (r_pending),
        .i_advance     (w_take),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
    );

    // A capture landing on the slot being loaded re-arms it instead of overrunning.
    always_comb begin
        w_hit       = {NUM_CH{1'b0}};
        w_pend_nxt  = r_pending;
        w_load_word = 32'h0000_0000;
        w_ovr_inc   = 4'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_hit[k]      = w_load && (r_grant == CH_W'(k));
            w_load_word   = w_load_word | ({32{w_hit[k]}} & r_slot[k]);
            w_pend_nxt[k] = iFrame_Valid[k] | (r_pending[k] & ~w_hit[k]);
            w_ovr_inc     = w_ovr_inc + 4'(iFrame_Valid[k] & r_pending[k] & ~w_hit[k]);
        end
    end

    // Holding slots.
    always_ff @(posedge CLOCK_50M) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (!RST_n) begin
                r_slot[k] <= 32'h0000_0000;
            end else if (iFrame_Valid[k]) begin
                r_slot[k] <= iFrame_Data[32*k +: 32];
            end else begin
                r_slot[k] <= r_slot[k];
            end
        end
    end

    // Packet FSM, pending flags and overrun counter.
    always_ff @(posedge CLOCK_50M) begin
        if (!RST_n) begin
            r_state     <= IDLE;
            r_pending   <= {NUM_CH{1'b0}};
            r_grant     <= {CH_W{1'b0}};
            r_pkt       <= {PKT_W{1'b0}};
            r_idx       <= 3'd0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_busy      <= 1'b0;
            r_active_ch <= {CH_W{1'b0}};
            r_ovr_cnt   <= 16'h0000;
        end else begin
            r_pending  <= w_pend_nxt;
            r_ovr_cnt  <= w_ovr_sum[16] ? 16'hFFFF : w_ovr_sum[15:0];
            r_tx_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_grant <= w_grant;
                        r_state <= LOAD;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                LOAD: begin
                    r_pkt <= {SYNC_BYTE, w_ch_byte,
                              w_load_word[RESR_MSB -: 8], w_load_word[RESR_MSB-8 -: 8],
                              w_load_word[RGS_MSB -: 8], w_load_word[RGS_MSB-8 -: 8],
                              frame_checksum(w_ch_byte, w_load_word)};
                    r_active_ch <= r_grant;
                    r_busy      <= 1'b1;
                    r_idx       <= 3'd0;
                    r_state     <= ISSUE;
                end
                ISSUE: begin
                    if (!iTx_Busy) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= r_pkt[PKT_W-1 -: 8];
                        r_pkt      <= {r_pkt[PKT_W-9:0], 8'h00};
                        r_state    <= HOLD;
                    end else begin
                        r_state <= ISSUE;
                    end
                end
                // The transmitter raises busy one cycle late, so skip sampling it here.
                HOLD: begin
                    r_state <= DRAIN;
                end
                DRAIN: begin
                    if (iTx_Busy) begin
                        r_state <= DRAIN;
                    end else if (r_idx == 3'(FRAME_BYTES-1)) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                        r_state <= ISSUE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign oTx_Start      = r_tx_start;
    assign oTx_Data       = r_tx_data;
    assign oBusy          = r_busy;
    assign oActive_Ch     = r_active_ch;
    assign oOverrun_Count = r_ovr_cnt;

endmodule

// File: tb/tb_meas_frame_scheduler.sv
// Directed bench for meas_frame_scheduler with a 10-cycle busy transmitter model.
module tb_meas_frame_scheduler;

    localparam int NUM_CH = 2;
    localparam int CH_W   = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_CH-1:0]     frame_valid;
    logic [32*NUM_CH-1:0]  frame_data;
    logic                  enable;
    logic                  tx_busy;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic                  busy;
    logic [CH_W-1:0]       active_ch;
    logic [15:0]           ovr_cnt;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         busy_cnt = 0;
    int         busy_viol = 0;
    logic [7:0] rx_q [$];

    typedef struct packed {
        logic [2:0]  ch;
        logic [31:0] word;
        logic [55:0] pkt;
    } vec_t;

    vec_t vecs [5];

    meas_frame_scheduler #(
        .NUM_CH    (NUM_CH),
        .SYNC_BYTE (8'hA5),
        .CH_W      (CH_W)
    ) dut (
        .CLOCK_50M      (clk),
        .RST_n          (rst_n),
        .iFrame_Valid   (frame_valid),
        .iFrame_Data    (frame_data),
        .iEnable        (enable),
        .iTx_Busy       (tx_busy),
        .oTx_Start      (tx_start),
        .oTx_Data       (tx_data),
        .oBusy          (busy),
        .oActive_Ch     (active_ch),
        .oOverrun_Count (ovr_cnt)
    );

    always #10 clk = ~clk;

    assign tx_busy = (busy_cnt != 0);

    // Transmitter model: records each byte and stays busy for 10 cycles.
    always @(negedge clk) begin
        if (tx_start) begin
            if (busy_cnt != 0) busy_viol <= busy_viol + 1;
            rx_q.push_back(tx_data);
            busy_cnt <= 10;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic strobe(input logic [1:0] mask, input logic [31:0] d0, input logic [31:0] d1);
        frame_valid = mask;
        frame_data  = {d1, d0};
        @(negedge clk);
        frame_valid = 2'b00;
    endtask

    task automatic wait_bytes(input int n, input string name);
        int c;
        c = 0;
        while (rx_q.size() < n && c < 1000) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while (busy && c < 100) begin
            @(negedge clk);
            c++;
        end
        check(name, {31'h0, busy}, 32'h0);
    endtask

    task automatic check_pkt(input string name, input int base, input logic [55:0] pkt);
        logic [31:0] got;
        for (int i = 0; i < 7; i++) begin
            got = (rx_q.size() > base + i) ? {24'h0, rx_q[base + i]} : 32'hDEAD;
            check($sformatf("%s_b%0d", name, i), got, {24'h0, pkt[55 - 8*i -: 8]});
        end
    endtask

    initial begin
        int lat;

        vecs[0] = '{ch: 3'd0, word: 32'h0012_0345, pkt: 56'hA5_00_00_12_03_45_5A};
        vecs[1] = '{ch: 3'd1, word: 32'hDEAD_BEEF, pkt: 56'hA5_01_DE_AD_BE_EF_39};
        vecs[2] = '{ch: 3'd0, word: 32'hFFFF_FFFF, pkt: 56'hA5_00_FF_FF_FF_FF_FC};
        vecs[3] = '{ch: 3'd0, word: 32'h8001_7F02, pkt: 56'hA5_00_80_01_7F_02_02};
        vecs[4] = '{ch: 3'd1, word: 32'h0000_0000, pkt: 56'hA5_01_00_00_00_00_01};

        rst_n       = 1'b0;
        frame_valid = 2'b00;
        frame_data  = 64'h0;
        enable      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_start",  {31'h0, tx_start}, 32'h0);
        check("rst_data",   {24'h0, tx_data},  32'h0);
        check("rst_busy",   {31'h0, busy},     32'h0);
        check("rst_active", {29'h0, active_ch}, 32'h0);
        check("rst_ovr",    {16'h0, ovr_cnt},  32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-frame vectors; the last one is ch1 so the pointer ends at 0.
        for (int v = 0; v < 5; v++) begin
            rx_q.delete();
            frame_valid = (vecs[v].ch == 3'd0) ? 2'b01 : 2'b10;
            frame_data  = {vecs[v].word, vecs[v].word};
            @(negedge clk);
            frame_valid = 2'b00;
            lat = 1;
            while (!tx_start && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("v%0d_latency", v), 32'(lat - 1), 32'd3);
            wait_bytes(7, $sformatf("v%0d_bytes", v));
            wait_idle($sformatf("v%0d_idle", v));
            check($sformatf("v%0d_active", v), {29'h0, active_ch}, {29'h0, vecs[v].ch});
            check($sformatf("v%0d_count", v), 32'(rx_q.size()), 32'd7);
            check_pkt($sformatf("v%0d", v), 0, vecs[v].pkt);
        end

        // Simultaneous captures: ch0 then ch1, twice.
        for (int r = 0; r < 2; r++) begin
            rx_q.delete();
            strobe(2'b11, 32'h0000_0001, 32'h0000_0002);
            wait_bytes(14, $sformatf("pair%0d_bytes", r));
            wait_idle($sformatf("pair%0d_idle", r));
            check_pkt($sformatf("pair%0d_ch0", r), 0, 56'hA5_00_00_00_00_01_01);
            check_pkt($sformatf("pair%0d_ch1", r), 7, 56'hA5_01_00_00_00_02_03);
        end

        // Overrun: ch1 written three times while ch0 is in flight.
        check("ovr_before", {16'h0, ovr_cnt}, 32'h0);
        rx_q.delete();
        strobe(2'b01, 32'h0000_0011, 32'h0);
        lat = 0;
        while (!busy && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        strobe(2'b10, 32'h0, 32'h1111_1111);
        @(negedge clk);
        strobe(2'b10, 32'h0, 32'h2222_2222);
        @(negedge clk);
        strobe(2'b10, 32'h0, 32'h3333_3333);
        check("ovr_mid", {16'h0, ovr_cnt}, 32'd2);
        wait_bytes(14, "ovr_bytes");
        wait_idle("ovr_idle");
        check("ovr_after", {16'h0, ovr_cnt}, 32'd2);
        check_pkt("ovr_ch0", 0, 56'hA5_00_00_00_00_11_11);
        check_pkt("ovr_ch1", 7, 56'hA5_01_33_33_33_33_CD);

        // Capture in the exact LOAD cycle of the same channel.
        rx_q.delete();
        frame_valid = 2'b01;
        frame_data  = {32'h0, 32'h0102_0304};
        @(negedge clk);
        frame_valid = 2'b00;
        @(negedge clk);
        frame_valid = 2'b01;
        frame_data  = {32'h0, 32'hAAAA_BBBB};
        @(negedge clk);
        frame_valid = 2'b00;
        wait_bytes(14, "coll_bytes");
        wait_idle("coll_idle");
        check("coll_ovr", {16'h0, ovr_cnt}, 32'd2);
        check_pkt("coll_old", 0, 56'hA5_00_01_02_03_04_0A);
        check_pkt("coll_new", 7, 56'hA5_00_AA_AA_BB_BB_CA);

        // iEnable dropped mid-packet.
        rx_q.delete();
        strobe(2'b10, 32'h0, 32'h0506_0708);
        wait_bytes(3, "en_b2");
        enable = 1'b0;
        strobe(2'b01, 32'h0000_00FF, 32'h0);
        wait_bytes(7, "en_first");
        wait_idle("en_idle1");
        repeat (30) @(negedge clk);
        check("en_held", 32'(rx_q.size()), 32'd7);
        enable = 1'b1;
        lat = 0;
        while (!tx_start && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("en_latency", 32'(lat), 32'd3);
        wait_bytes(14, "en_second");
        wait_idle("en_idle2");
        check_pkt("en_ch1", 0, 56'hA5_01_05_06_07_08_1B);
        check_pkt("en_ch0", 7, 56'hA5_00_00_00_00_FF_FF);

        // Reset during byte4.
        rx_q.delete();
        strobe(2'b10, 32'h0, 32'h1234_5678);
        wait_bytes(5, "rst_b4");
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_start",  {31'h0, tx_start}, 32'h0);
        check("mrst_data",   {24'h0, tx_data},  32'h0);
        check("mrst_busy",   {31'h0, busy},     32'h0);
        check("mrst_active", {29'h0, active_ch}, 32'h0);
        check("mrst_ovr",    {16'h0, ovr_cnt},  32'h0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("mrst_no_more", 32'(rx_q.size()), 32'd5);
        rx_q.delete();
        strobe(2'b01, 32'h0A0B_0C0D, 32'h0);
        wait_bytes(7, "post_bytes");
        wait_idle("post_idle");
        check_pkt("post", 0, 56'hA5_00_0A_0B_0C_0D_2E);

        check("busy_violations", 32'(busy_viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
